// File: rtl/bank_pkg.sv
// Shared types and sizing for the path-counting bank.
// Packet layout: node address, control code, and a 64-bit payload with three views.
// The payload views share one width so they can overlay as a packed union.
package bank_pkg;
    localparam int NUM_NODES          = 1024;
    localparam int NODE_W             = $clog2(NUM_NODES);
    localparam int MAX_PARENTS        = 32;
    localparam int MAX_EDGES_PER_LOAD = 4;
    localparam int VALUE_W            = 64;
    localparam int CNT_W              = NODE_W + 1;
    localparam int PCNT_W             = $clog2(MAX_PARENTS + 1);
    localparam int PIDX_W             = $clog2(MAX_PARENTS);
    localparam int NE_W               = $clog2(MAX_EDGES_PER_LOAD + 1);

    typedef enum logic [1:0] {
        CTRL_PARENTS = 2'd0,
        CTRL_CONFIG  = 2'd1,
        CTRL_SUM     = 2'd2,
        CTRL_RESULT  = 2'd3
    } ctrl_t;

    typedef struct packed {
        logic [NODE_W-1:0] node_id;
    } edge_t;

    typedef struct packed {
        logic [VALUE_W-NE_W-MAX_EDGES_PER_LOAD*NODE_W-1:0] pad;
        logic [NE_W-1:0]                                   num_edges;
        edge_t [MAX_EDGES_PER_LOAD-1:0]                    edges;
    } parents_t;

    typedef struct packed {
        logic [VALUE_W-CNT_W-2:0] pad;
        logic                     is_you;
        logic [CNT_W-1:0]         num_children;
    } config_t;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
    } sum_t;

    typedef union packed {
        parents_t parents;
        config_t  cfg;
        sum_t     sum;
    } data_t;

    typedef struct packed {
        logic [NODE_W-1:0] z;
    } addr_t;

    typedef struct packed {
        addr_t addr;
        ctrl_t ctrl;
        data_t data;
    } pkt_t;

    // Arrival counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction
endpackage

// File: rtl/bank_fifo.sv
// Generic single-clock FIFO with show-ahead read data (power-of-two depth).
// Latency: pushed entry visible at pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/bank.sv
// One bank of the DAG path-count engine: loads node tables, propagates counts sink->you, emits one result.
// Latency: a fired node is popped one cycle after idle, then one cycle per parent (one cycle if none).
// Backpressure: router input accepted only in IDLE; result held stable until router_ready_out.
module bank
    import bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic router_valid_in,
    output logic router_ready_in,
    input  pkt_t router_in_pkt,
    output logic router_valid_out,
    input  logic router_ready_out,
    output pkt_t router_out_pkt
);
    typedef enum logic [1:0] {IDLE, PROP, EMIT} state_t;

    state_t state, state_nxt;

    // Large tables are not reset; a per-node live bit makes unwritten entries read as zero.
    logic [NODE_W-1:0]  parents      [NUM_NODES][MAX_PARENTS];
    logic [PCNT_W-1:0]  parent_cnt   [NUM_NODES];
    logic [VALUE_W-1:0] acc          [NUM_NODES];
    logic [CNT_W-1:0]   recv_cnt     [NUM_NODES];
    logic [CNT_W-1:0]   num_children [NUM_NODES];
    logic [NUM_NODES-1:0] live, configured, done, is_you;

    logic [NODE_W-1:0]  cur_node;
    logic [VALUE_W-1:0] cur_val;
    logic [PCNT_W-1:0]  par_idx;
    logic [PCNT_W-1:0]  cur_pcnt;

    logic in_xfer, pop, fifo_empty, fifo_full, fifo_push;
    logic [NODE_W-1:0]  fifo_head;
    logic [VALUE_W-1:0] head_val;

    logic               tgt_sum, tgt_cfg, tgt_par, upd, fire;
    logic [NODE_W-1:0]  tgt;
    logic [VALUE_W-1:0] tgt_val, new_acc;
    logic [CNT_W-1:0]   new_cnt, new_nch;
    logic [PCNT_W-1:0]  old_pcnt, new_pcnt, pcnt_add;
    logic [PCNT_W-1:0]  wr_idx [MAX_EDGES_PER_LOAD];
    logic [MAX_EDGES_PER_LOAD-1:0] wr_en;

    assign in_xfer   = router_valid_in && router_ready_in;
    assign pop       = (state == IDLE) && !in_xfer && !fifo_empty;
    assign fifo_push = fire && !fifo_full;
    assign cur_pcnt  = live[cur_node] ? parent_cnt[cur_node] : '0;

    // A sink contributes 1; any other node contributes its accumulated children sum.
    always_comb begin
        head_val = live[fifo_head] ? acc[fifo_head] : '0;
        if (!live[fifo_head] || num_children[fifo_head] == '0) head_val = VALUE_W'(1);
    end

    // Select the single node updated this cycle (input packet or one parent step) and evaluate its fire check.
    always_comb begin
        tgt      = router_in_pkt.addr.z;
        tgt_val  = router_in_pkt.data.sum.value;
        tgt_sum  = 1'b0;
        tgt_cfg  = 1'b0;
        tgt_par  = 1'b0;
        if (in_xfer) begin
            tgt_sum = (router_in_pkt.ctrl == CTRL_SUM);
            tgt_cfg = (router_in_pkt.ctrl == CTRL_CONFIG);
            tgt_par = (router_in_pkt.ctrl == CTRL_PARENTS);
        end else if (state == PROP && cur_pcnt != '0) begin
            tgt     = parents[cur_node][par_idx[PIDX_W-1:0]];
            tgt_val = cur_val;
            tgt_sum = 1'b1;
        end
        new_acc  = live[tgt] ? acc[tgt] : '0;
        new_cnt  = live[tgt] ? recv_cnt[tgt] : '0;
        new_nch  = live[tgt] ? num_children[tgt] : '0;
        old_pcnt = live[tgt] ? parent_cnt[tgt] : '0;
        if (tgt_sum) begin
            new_acc = new_acc + tgt_val;
            new_cnt = sat_inc(new_cnt);
        end
        if (tgt_cfg) new_nch = router_in_pkt.data.cfg.num_children;
        pcnt_add = '0;
        for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) begin
            wr_idx[i] = old_pcnt + PCNT_W'(i);
            wr_en[i]  = tgt_par && (NE_W'(i) < router_in_pkt.data.parents.num_edges)
                        && (wr_idx[i] < PCNT_W'(MAX_PARENTS));
            pcnt_add  = pcnt_add + PCNT_W'(wr_en[i]);
        end
        new_pcnt = old_pcnt + pcnt_add;
        upd      = tgt_sum || tgt_cfg || tgt_par;
        fire     = (tgt_sum || tgt_cfg) && (configured[tgt] || tgt_cfg) && !done[tgt]
                   && (new_cnt == new_nch);
    end

    // Node data tables: whole entry rewritten on any update so the live bit can cover it.
    always_ff @(posedge clk) begin
        if (upd) begin
            acc[tgt]          <= new_acc;
            recv_cnt[tgt]     <= new_cnt;
            num_children[tgt] <= new_nch;
            parent_cnt[tgt]   <= new_pcnt;
        end
        for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) begin
            if (wr_en[i]) parents[tgt][wr_idx[i][PIDX_W-1:0]] <= router_in_pkt.data.parents.edges[i].node_id;
        end
    end

    // Per-node flags, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live       <= '0;
            configured <= '0;
            done       <= '0;
            is_you     <= '0;
        end else begin
            if (upd) live[tgt] <= 1'b1;
            if (tgt_cfg) begin
                configured[tgt] <= 1'b1;
                is_you[tgt]     <= router_in_pkt.data.cfg.is_you;
            end
            if (fire) done[tgt] <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(NODE_W), .DEPTH(NUM_NODES)) u_ready_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (fifo_push),
        .push_dat (tgt),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // FSM state and the node currently being propagated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_node <= '0;
            cur_val  <= '0;
            par_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_node <= fifo_head;
                cur_val  <= head_val;
                par_idx  <= '0;
            end else if (state == PROP) begin
                par_idx <= par_idx + PCNT_W'(1);
            end
        end
    end

    // Next state: input beats popping; you goes straight to EMIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop) state_nxt = is_you[fifo_head] ? EMIT : PROP;
            PROP: if (cur_pcnt == '0 || par_idx == cur_pcnt - PCNT_W'(1)) state_nxt = IDLE;
            EMIT: if (router_ready_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Router outputs derived from state; all zero outside EMIT and during reset.
    always_comb begin
        router_ready_in  = rst && (state == IDLE);
        router_valid_out = (state == EMIT);
        router_out_pkt   = '0;
        if (state == EMIT) begin
            router_out_pkt.addr.z         = cur_node;
            router_out_pkt.ctrl           = CTRL_RESULT;
            router_out_pkt.data.sum.value = cur_val;
        end
    end
endmodule

// File: tb/tb_bank.sv
// Scoreboard bench for bank: stimulus pushes expected result packets, a negedge monitor pops and compares.
// Expected path counts come from fixed graph answers or a topological path-count model of random DAGs.
// Also checks output stability under backpressure and quiet outputs while reset is low.
module tb_bank;
    import bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic router_valid_in = 1'b0;
    logic router_ready_in;
    logic router_valid_out;
    logic router_ready_out = 1'b1;
    pkt_t router_in_pkt = '0;
    pkt_t router_out_pkt;

    int   checks = 0;
    int   fails = 0;
    int   n_results = 0;
    int   n_expected = 0;
    pkt_t exp_q[$];
    bit   prev_stall = 1'b0;
    pkt_t prev_pkt = '0;

    int          k;
    int unsigned ids [16];
    bit          adj [16][16];
    int          ord [16];

    bank dut (
        .clk              (clk),
        .rst              (rst),
        .router_valid_in  (router_valid_in),
        .router_ready_in  (router_ready_in),
        .router_in_pkt    (router_in_pkt),
        .router_valid_out (router_valid_out),
        .router_ready_out (router_ready_out),
        .router_out_pkt   (router_out_pkt)
    );

    always #5 clk = ~clk;

    // Monitor: reset quietness, hold-while-stalled, and scoreboard compare on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (router_valid_out !== 1'b0 || router_ready_in !== 1'b0 || router_out_pkt !== '0) begin
                fails++;
                $display("FAIL reset_quiet: valid_out=%b ready_in=%b pkt=%h, required 0 0 0",
                         router_valid_out, router_ready_in, router_out_pkt);
            end
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (router_valid_out !== 1'b1 || router_out_pkt !== prev_pkt) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b pkt=%h, required 1 %h", router_valid_out, router_out_pkt, prev_pkt);
                end
            end
            if (router_valid_out && router_ready_out) begin
                n_results++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL result_unexpected: got pkt=%h, required no output", router_out_pkt);
                end else begin
                    if (router_out_pkt !== exp_q[0]) begin
                        fails++;
                        $display("FAIL result: got pkt=%h, required %h", router_out_pkt, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = router_valid_out && !router_ready_out;
            prev_pkt   = router_out_pkt;
        end
    end

    task automatic send(input pkt_t p);
        int t;
        t = 0;
        router_in_pkt   = p;
        router_valid_in = 1'b1;
        while (1) begin
            @(negedge clk);
            if (router_ready_in) break;
            t++;
            if (t > 2000) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: ready_in stayed 0 for %0d cycles, required 1", t);
                break;
            end
        end
        @(posedge clk);
        #1;
        router_valid_in = 1'b0;
    endtask

    task automatic send_parents(input int n);
        int   lst[$];
        int   cnt;
        pkt_t p;
        for (int i = 0; i < k; i++) if (adj[i][n]) lst.push_back(i);
        for (int s = 0; s < lst.size(); s += 4) begin
            p = '0;
            p.addr.z = NODE_W'(ids[n]);
            p.ctrl   = CTRL_PARENTS;
            cnt = (lst.size() - s > 4) ? 4 : lst.size() - s;
            p.data.parents.num_edges = NE_W'(cnt);
            for (int e = 0; e < cnt; e++) p.data.parents.edges[e].node_id = NODE_W'(ids[lst[s+e]]);
            send(p);
        end
    endtask

    task automatic send_config(input int n);
        int   nch;
        pkt_t p;
        nch = 0;
        for (int j = 0; j < k; j++) if (adj[n][j]) nch++;
        p = '0;
        p.addr.z = NODE_W'(ids[n]);
        p.ctrl   = CTRL_CONFIG;
        p.data.cfg.is_you       = (n == 0);
        p.data.cfg.num_children = CNT_W'(nch);
        send(p);
    endtask

    task automatic send_sum(input int unsigned z, input logic [63:0] v);
        pkt_t p;
        p = '0;
        p.addr.z = NODE_W'(z);
        p.ctrl   = CTRL_SUM;
        p.data.sum.value = v;
        send(p);
    endtask

    // split=0: each node's parents then config in load order; split=1: all parents first, then configs.
    task automatic load_graph(input bit split);
        if (split) begin
            for (int oi = 0; oi < k; oi++) send_parents(ord[oi]);
            for (int oi = 0; oi < k; oi++) send_config(ord[oi]);
        end else begin
            for (int oi = 0; oi < k; oi++) begin
                send_parents(ord[oi]);
                send_config(ord[oi]);
            end
        end
    endtask

    task automatic new_graph(input int nk);
        k = nk;
        for (int i = 0; i < 16; i++) begin
            ids[i] = 37 * i + 5;
            ord[i] = i;
            for (int j = 0; j < 16; j++) adj[i][j] = 1'b0;
        end
    endtask

    // Node 0 is you, node k-1 is out; edges always point to a higher index.
    function automatic logic [63:0] ref_paths();
        logic [63:0] cnt [16];
        for (int i = k - 1; i >= 0; i--) begin
            cnt[i] = (i == k - 1) ? 64'd1 : 64'd0;
            for (int j = i + 1; j < k; j++) if (adj[i][j]) cnt[i] = cnt[i] + cnt[j];
        end
        return cnt[0];
    endfunction

    task automatic expect_result(input int unsigned z, input logic [63:0] v);
        pkt_t e;
        e = '0;
        e.addr.z = NODE_W'(z);
        e.ctrl   = CTRL_RESULT;
        e.data.sum.value = v;
        exp_q.push_back(e);
        n_expected++;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL result_timeout: %0d results outstanding after %0d cycles, required 0", exp_q.size(), t);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic diamond();
        new_graph(4);
        adj[0][1] = 1; adj[0][2] = 1; adj[1][3] = 1; adj[2][3] = 1;
    endtask

    task automatic example_graph();
        new_graph(8);
        adj[0][1] = 1; adj[0][2] = 1;
        adj[1][3] = 1; adj[1][4] = 1;
        adj[2][3] = 1; adj[2][4] = 1; adj[2][5] = 1;
        adj[3][6] = 1; adj[4][7] = 1; adj[5][7] = 1; adj[6][7] = 1;
        ord[0] = 1; ord[1] = 2; ord[2] = 3; ord[3] = 4;
        ord[4] = 5; ord[5] = 6; ord[6] = 0; ord[7] = 7;
    endtask

    task automatic random_graph();
        bit dup, has;
        int j, tmp;
        new_graph($urandom_range(3, 12));
        for (int i = 0; i < k; i++) begin
            do begin
                ids[i] = $urandom_range(0, NUM_NODES - 1);
                dup = 1'b0;
                for (int m = 0; m < i; m++) if (ids[m] == ids[i]) dup = 1'b1;
            end while (dup);
        end
        for (int i = 0; i < k - 1; i++) begin
            has = 1'b0;
            for (int c = i + 1; c < k; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    adj[i][c] = 1'b1;
                    has = 1'b1;
                end
            end
            if (!has) adj[i][$urandom_range(i + 1, k - 1)] = 1'b1;
        end
        for (int i = k - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
    endtask

    initial begin
        logic [63:0] v1, v2;
        int t;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Chain you -> out.
        new_graph(2);
        adj[0][1] = 1;
        expect_result(ids[0], 64'd1);
        load_graph(1'b0);
        wait_done();
        do_reset();

        // Diamond.
        diamond();
        expect_result(ids[0], 64'd2);
        load_graph(1'b0);
        wait_done();
        do_reset();

        // Example graph, alphabetical with out last.
        example_graph();
        expect_result(ids[0], 64'd5);
        load_graph(1'b0);
        wait_done();
        do_reset();

        // Out with six parents, loaded as 4 + 2 edges.
        new_graph(8);
        for (int p = 1; p <= 6; p++) begin
            adj[0][p] = 1;
            adj[p][7] = 1;
        end
        expect_result(ids[0], 64'd6);
        load_graph(1'b0);
        wait_done();
        do_reset();

        // External sums arriving before config, with 64-bit wraparound.
        new_graph(1);
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        v1 = v1 | 64'h8000_0000_0000_0000;
        expect_result(ids[0], v1 + v2);
        send_sum(ids[0], v1);
        send_sum(ids[0], v2);
        begin
            pkt_t p;
            p = '0;
            p.addr.z = NODE_W'(ids[0]);
            p.ctrl   = CTRL_CONFIG;
            p.data.cfg.is_you       = 1'b1;
            p.data.cfg.num_children = CNT_W'(2);
            send(p);
        end
        wait_done();
        do_reset();

        // Random DAGs with random ids and random config order.
        for (int r = 0; r < 6; r++) begin
            random_graph();
            expect_result(ids[0], ref_paths());
            load_graph(1'b1);
            wait_done();
            do_reset();
        end

        // Backpressure: hold ready_out low for 10 cycles after valid.
        diamond();
        router_ready_out = 1'b0;
        expect_result(ids[0], 64'd2);
        load_graph(1'b0);
        t = 0;
        while (!router_valid_out && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (!router_valid_out) begin
            fails++;
            $display("FAIL bp_valid: valid_out=%b after %0d cycles, required 1", router_valid_out, t);
        end
        repeat (10) @(posedge clk);
        #1;
        router_ready_out = 1'b1;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        do_reset();

        // Reset in the middle of propagation, then a clean diamond.
        example_graph();
        expect_result(ids[0], 64'd5);
        load_graph(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_expected--;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        diamond();
        expect_result(ids[0], 64'd2);
        load_graph(1'b0);
        wait_done();
        repeat (5) @(posedge clk);
        #1;

        checks++;
        if (n_results != n_expected) begin
            fails++;
            $display("FAIL result_count: got %0d transfers, required %0d", n_results, n_expected);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
